tcbus_target_regfile: RTL and testbench
=======================================

Name: tcbus_target_regfile

Overview:
- TC-bus target (slave) sitting directly downstream of the TC-bus request interface.
- Consumes requests from the bus master, acknowledges the address phase, and queues accepted commands.
- Executes queued commands in order against an internal register file and returns per-command read/write acknowledges after a fixed service latency.
- Provides the responder side of the pipelined protocol that the bus protocol checker constrains.

Parameters:
TC_AWIDTH, 8, address width; register file holds 2**TC_AWIDTH words
TC_DWIDTH, 8, data width
MAX_OUT, 4, maximum outstanding accepted-but-unacknowledged commands (legal 1..7)
RESP_LAT, 2, wait cycles per command before its ack (legal 1..15)

Ports:
clk_bus  in  1  bus clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tc_req  in  1  master request, held until tc_aack
tc_rnw  in  1  1=read, 0=write; stable while tc_req && !tc_aack
tc_addr  in  TC_AWIDTH  request address
tc_wdata  in  TC_DWIDTH  write data
tc_aack  out  1  address-phase accept (combinational)
tc_rack  out  1  read complete, one-cycle pulse, registered
tc_wack  out  1  write complete, one-cycle pulse, registered
tc_rdata  out  TC_DWIDTH  read data, valid when tc_rack=1, held afterwards
tc_stall  in  1  present only with TCS_STALL_EN (see below)

Behaviour:
- Reset: tc_rack=0, tc_wack=0, tc_rdata=0, command queue empty, occupancy count=0, FSM=IDLE, lat_cnt=0, all register file words=0.
- Reset asserted mid-operation flushes the queue; no ack is issued for flushed commands.
- Accept: tc_aack = tc_req && (count_ff < MAX_OUT).
  - Uses the registered count only; no bypass when a retire happens in the same cycle.
  - On aack, {tc_rnw, tc_addr, tc_wdata} is pushed into a MAX_OUT-deep FIFO.
- Occupancy count:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged.
  - Width is clog2(MAX_OUT+1); never exceeds MAX_OUT and never underflows.
- FSM states IDLE, WAIT, ACK:
  - IDLE: if count_ff!=0, go to WAIT and load lat_cnt=RESP_LAT-1.
  - WAIT: if lat_cnt==0, go to ACK; otherwise lat_cnt decrements.
  - ACK: acts on the FIFO head.
    - Write: mem[addr]<=wdata, tc_wack=1.
    - Read: tc_rdata<=mem[addr], tc_rack=1.
    - Head is popped this cycle.
    - Next state is WAIT with lat_cnt reloaded if count_ff>1, else IDLE.
- tc_rack and tc_wack are never both high. Each is high for exactly one cycle per command.
- Latency:
  - Command accepted at cycle N into an empty target: ack at cycle N+RESP_LAT+2.
  - Back-to-back queued commands: one ack every RESP_LAT+1 cycles.
- Ordering: strict FIFO order across reads and writes. A read after a write to the same address returns the new data.
- Ack never occurs in the same cycle as that command's aack, so the pending-count invariants hold.
- Full: at count_ff==MAX_OUT, aack=0 and the request stays pending. aack reasserts the cycle after the pop that made count_ff<MAX_OUT.
- Addresses use all TC_AWIDTH bits; there is no out-of-range case.

Optional Feature:
- TCS_STALL_EN defined:
  - Adds the tc_stall input.
  - While tc_stall=1, tc_aack is forced to 0 and the FSM/lat_cnt freeze, so no ACK is issued.
  - Queue contents and count are held.
  - Stall asserted during ACK delays the pulse: ACK is executed on the first cycle with tc_stall=0.
- Undefined: the port is absent and the block behaves as if tc_stall=0.

Test Plan:
1. Reset, then write addr 0x10 data 0xA5 at cycle N (RESP_LAT=2) -> aack at N, tc_wack at N+4, count returns to 0.
2. Read 0x10 after test 1 -> tc_rack at its N+4 with tc_rdata=0xA5; tc_rdata stays 0xA5 afterwards.
3. Issue 5 back-to-back writes with MAX_OUT=4 -> first 4 aacked on consecutive cycles, 5th held with aack=0 until the cycle after the first tc_wack; wacks spaced 3 cycles apart.
4. Write 0x33 to 0x07 then immediately read 0x07 (both queued) -> wack, then 3 cycles later rack with tc_rdata=0x33.
5. Deassert rst_n with 3 commands queued -> no acks, count=0, tc_rdata=0; a subsequent read of any address returns 0x00.
6. TCS_STALL_EN: hold tc_stall=1 for 5 cycles over a pending write -> tc_wack delayed by exactly 5 cycles; no aack while stalled.

Source files
------------

// File: rtl/tcbus_target_regfile.sv
// rtl/tcbus_target_regfile.sv - TC-bus target with in-order command queue and register file
//
// Accepts TC-bus requests into a MAX_OUT-deep FIFO and executes them in order
// against a 2**TC_AWIDTH word register file. Each command is acknowledged
// RESP_LAT+1 cycles after the FSM picks it up.
//
// Optional build macro: TCS_STALL_EN (adds tc_stall, freezes accept and FSM).
//
// Ports:
//   clk_bus   in   bus clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tc_stall  in   stall (only with TCS_STALL_EN)
//   tc_req    in   master request, held until tc_aack
//   tc_rnw    in   1=read, 0=write
//   tc_addr   in   request address
//   tc_wdata  in   write data
//   tc_aack   out  address-phase accept (combinational)
//   tc_rack   out  read complete pulse
//   tc_wack   out  write complete pulse
//   tc_rdata  out  read data, valid with tc_rack, held afterwards

module tcbus_target_regfile #(
    parameter int TC_AWIDTH = 8,
    parameter int TC_DWIDTH = 8,
    parameter int MAX_OUT   = 4,
    parameter int RESP_LAT  = 2
) (
    input  logic                 clk_bus,
    input  logic                 rst_n,
`ifdef TCS_STALL_EN
    input  logic                 tc_stall,
`endif
    input  logic                 tc_req,
    input  logic                 tc_rnw,
    input  logic [TC_AWIDTH-1:0] tc_addr,
    input  logic [TC_DWIDTH-1:0] tc_wdata,
    output logic                 tc_aack,
    output logic                 tc_rack,
    output logic                 tc_wack,
    output logic [TC_DWIDTH-1:0] tc_rdata
);

    localparam int EW    = 1 + TC_AWIDTH + TC_DWIDTH;
    localparam int CW    = $clog2(MAX_OUT + 1);
    localparam int PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int DEPTH = 1 << TC_AWIDTH;

    localparam logic [CW-1:0] MAX_C      = CW'(MAX_OUT);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [3:0]    LAT_RELOAD = 4'(RESP_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_lat_cnt;
    logic [CW-1:0]          r_count;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [EW-1:0]          r_fifo [MAX_OUT];
    logic [TC_DWIDTH-1:0]   r_mem  [DEPTH];
    logic                   r_rack;
    logic                   r_wack;
    logic [TC_DWIDTH-1:0]   r_rdata;

    logic                   w_stall;
    logic                   w_push;
    logic                   w_pop;
    logic [EW-1:0]          w_head;
    logic                   w_head_rnw;
    logic [TC_AWIDTH-1:0]   w_head_addr;
    logic [TC_DWIDTH-1:0]   w_head_wdata;

`ifdef TCS_STALL_EN
    assign w_stall = tc_stall;
`else
    assign w_stall = 1'b0;
`endif

    // Accept is based on the registered count only; a retire in the same
    // cycle does not open a slot until the following cycle.
    assign tc_aack = tc_req && (r_count < MAX_C) && !w_stall;
    assign w_push  = tc_aack;
    assign w_pop   = (r_state == S_ACK) && !w_stall;

    assign w_head       = r_fifo[r_rd_ptr];
    assign w_head_rnw   = w_head[EW-1];
    assign w_head_addr  = w_head[TC_AWIDTH+TC_DWIDTH-1:TC_DWIDTH];
    assign w_head_wdata = w_head[TC_DWIDTH-1:0];

    // A stall arriving while in ACK keeps the pulse registered but hidden;
    // it shows on the first unstalled cycle, which is when the pop happens.
    assign tc_rack  = r_rack && !w_stall;
    assign tc_wack  = r_wack && !w_stall;
    assign tc_rdata = r_rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_bus) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {tc_rnw, tc_addr, tc_wdata};
        end
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    // The command executes on the WAIT->ACK transition so that the ack pulse
    // and read data are registered and visible during the ACK cycle itself.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= '0;
            r_rack    <= 1'b0;
            r_wack    <= 1'b0;
            r_rdata   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_stall) begin
            r_rack <= (r_state == S_ACK) ? r_rack : 1'b0;
            r_wack <= (r_state == S_ACK) ? r_wack : 1'b0;
        end else begin
            r_rack <= 1'b0;
            r_wack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state   <= S_WAIT;
                        r_lat_cnt <= LAT_RELOAD;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= S_ACK;
                        if (w_head_rnw) begin
                            r_rdata <= r_mem[w_head_addr];
                            r_rack  <= 1'b1;
                        end else begin
                            r_mem[w_head_addr] <= w_head_wdata;
                            r_wack             <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    if (r_count > ONE_C) begin
                        r_state   <= S_WAIT;
                        r_lat_cnt <= LAT_RELOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcbus_target_regfile.sv
// tb/tb_tcbus_target_regfile.sv - directed self-checking bench for tcbus_target_regfile

module tb_tcbus_target_regfile;

    logic       clk_bus = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tc_req  = 1'b0;
    logic       tc_rnw  = 1'b0;
    logic [7:0] tc_addr = 8'h00;
    logic [7:0] tc_wdata = 8'h00;
    logic       tc_aack;
    logic       tc_rack;
    logic       tc_wack;
    logic [7:0] tc_rdata;
`ifdef TCS_STALL_EN
    logic       tc_stall = 1'b0;
`endif

    tcbus_target_regfile #(
        .TC_AWIDTH (8),
        .TC_DWIDTH (8),
        .MAX_OUT   (4),
        .RESP_LAT  (2)
    ) dut (
        .clk_bus  (clk_bus),
        .rst_n    (rst_n),
`ifdef TCS_STALL_EN
        .tc_stall (tc_stall),
`endif
        .tc_req   (tc_req),
        .tc_rnw   (tc_rnw),
        .tc_addr  (tc_addr),
        .tc_wdata (tc_wdata),
        .tc_aack  (tc_aack),
        .tc_rack  (tc_rack),
        .tc_wack  (tc_wack),
        .tc_rdata (tc_rdata)
    );

    always #5 clk_bus = ~clk_bus;

    int cyc = 0;
    always @(posedge clk_bus) cyc <= cyc + 1;

    typedef struct {
        int         c;
        bit         rd;
        logic [7:0] d;
    } ack_t;

    ack_t ack_q[$];
    bit   both_seen = 1'b0;

    always @(negedge clk_bus) begin
        if (tc_rack || tc_wack) begin
            ack_q.push_back('{c: cyc, rd: tc_rack, d: tc_rdata});
        end
        if (tc_rack && tc_wack) both_seen = 1'b1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic align();
        @(posedge clk_bus);
        #1;
    endtask

    // Caller is aligned at posedge+1; returns aligned at posedge+1 after aack.
    task automatic do_cmd(input string tag, input bit rnw, input logic [7:0] a,
                          input logic [7:0] d, output int acc);
        bit seen = 1'b0;
        acc      = -1;
        tc_req   = 1'b1;
        tc_rnw   = rnw;
        tc_addr  = a;
        tc_wdata = d;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_bus);
            if (tc_aack) begin
                seen = 1'b1;
                acc  = cyc;
            end
            @(posedge clk_bus);
            #1;
        end
        tc_req = 1'b0;
        if (!seen) check({tag, " aack timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_ack(input string tag, output int c, output bit rd, output logic [7:0] d);
        ack_t e;
        for (int i = 0; i < 200 && ack_q.size() == 0; i++) @(posedge clk_bus);
        if (ack_q.size() == 0) begin
            check({tag, " ack timeout"}, 32'd0, 32'd1);
            c  = 0;
            rd = 1'b0;
            d  = 8'h00;
        end else begin
            e  = ack_q.pop_front();
            c  = e.c;
            rd = e.rd;
            d  = e.d;
        end
    endtask

    int         a0, a1, n, w0, prev;
    int         acc [5];
    int         ac;
    bit         ard;
    logic [7:0] ad;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_bus);
        check("rst_rack",  32'(tc_rack),  32'd0);
        check("rst_wack",  32'(tc_wack),  32'd0);
        check("rst_rdata", 32'(tc_rdata), 32'd0);
        check("rst_aack",  32'(tc_aack),  32'd0);
        check("rst_count", 32'(dut.r_count), 32'd0);
        align();
        rst_n = 1'b1;
        repeat (2) align();

        // 1: single write, ack at N+4
        do_cmd("t1", 1'b0, 8'h10, 8'hA5, n);
        wait_ack("t1", ac, ard, ad);
        check("t1_lat",  32'(ac - n), 32'd4);
        check("t1_kind", 32'(ard), 32'd0);
        @(negedge clk_bus);
        check("t1_count", 32'(dut.r_count), 32'd0);

        // 2: read back, data held afterwards
        align();
        do_cmd("t2", 1'b1, 8'h10, 8'h00, n);
        wait_ack("t2", ac, ard, ad);
        check("t2_lat",  32'(ac - n), 32'd4);
        check("t2_kind", 32'(ard), 32'd1);
        check("t2_data", 32'(ad), 32'hA5);
        repeat (3) @(negedge clk_bus);
        check("t2_hold", 32'(tc_rdata), 32'hA5);

        // 3: five back-to-back writes into a 4-deep queue
        align();
        for (int i = 0; i < 5; i++) begin
            do_cmd("t3", 1'b0, 8'(8'h20 + i), 8'(8'h50 + i), acc[i]);
        end
        for (int i = 1; i < 4; i++) begin
            check("t3_acc_b2b", 32'(acc[i] - acc[0]), 32'(i));
        end
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_ack("t3", ac, ard, ad);
            check("t3_kind", 32'(ard), 32'd0);
            if (i == 0) begin
                w0 = ac;
                check("t3_first_lat", 32'(ac - acc[0]), 32'd4);
            end else begin
                check("t3_spacing", 32'(ac - prev), 32'd3);
            end
            prev = ac;
        end
        check("t3_fifth_acc", 32'(acc[4] - w0), 32'd1);

        // 4: write then read same address, both queued
        align();
        do_cmd("t4w", 1'b0, 8'h07, 8'h33, a0);
        do_cmd("t4r", 1'b1, 8'h07, 8'h00, a1);
        check("t4_b2b", 32'(a1 - a0), 32'd1);
        wait_ack("t4w", ac, ard, ad);
        check("t4_wkind", 32'(ard), 32'd0);
        prev = ac;
        wait_ack("t4r", ac, ard, ad);
        check("t4_rkind", 32'(ard), 32'd1);
        check("t4_gap",   32'(ac - prev), 32'd3);
        check("t4_data",  32'(ad), 32'h33);

        // 5: reset with three commands queued
        align();
        ack_q.delete();
        do_cmd("t5a", 1'b0, 8'h30, 8'h11, n);
        do_cmd("t5b", 1'b0, 8'h31, 8'h22, n);
        do_cmd("t5c", 1'b1, 8'h07, 8'h00, n);
        rst_n = 1'b0;
        @(negedge clk_bus);
        check("t5_count", 32'(dut.r_count), 32'd0);
        check("t5_rdata", 32'(tc_rdata), 32'd0);
        check("t5_acks",  32'({tc_rack, tc_wack}), 32'd0);
        align();
        rst_n = 1'b1;
        repeat (8) @(negedge clk_bus);
        check("t5_no_ack", 32'(ack_q.size()), 32'd0);
        align();
        do_cmd("t5r1", 1'b1, 8'h07, 8'h00, n);
        wait_ack("t5r1", ac, ard, ad);
        check("t5_rd07", 32'(ad), 32'h00);
        align();
        do_cmd("t5r2", 1'b1, 8'h22, 8'h00, n);
        wait_ack("t5r2", ac, ard, ad);
        check("t5_rd22", 32'(ad), 32'h00);

`ifdef TCS_STALL_EN
        // 6: stall for 5 cycles over a pending write
        align();
        do_cmd("t6w", 1'b0, 8'h10, 8'h3C, n);
        tc_stall = 1'b1;
        tc_req   = 1'b1;
        tc_rnw   = 1'b1;
        tc_addr  = 8'h10;
        a1       = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_bus);
            if (tc_aack) a1++;
            align();
        end
        check("t6_no_aack", 32'(a1), 32'd0);
        tc_stall = 1'b0;
        @(negedge clk_bus);
        check("t6_aack_resume", 32'(tc_aack), 32'd1);
        align();
        tc_req = 1'b0;
        wait_ack("t6w", ac, ard, ad);
        check("t6_wlat", 32'(ac - n), 32'd9);
        check("t6_wkind", 32'(ard), 32'd0);
        wait_ack("t6r", ac, ard, ad);
        check("t6_rlat", 32'(ac - n), 32'd12);
        check("t6_rdata", 32'(ad), 32'h3C);
`endif

        check("never_both_acks", 32'(both_seen), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
